// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, one APB transfer at a time, forced timeout.
// Latency: grant on the first edge after an eligible rq_valid; SETUP 1 cycle, ACCESS >= 1 cycle, rq_done one cycle after pready.
// Backpressure: pready stretches ACCESS up to TIMEOUT cycles; other requesters wait in rq_valid until granted.
// Ports:
//   pclk, presetn              clock, async active-low reset
//   rq_valid/write/addr/wdata/strb  packed per-requester request fields (requester i in slice i)
//   rq_done, rq_rdata, rq_err  completion pulse to the granted requester, held read data / error
//   psel..pstrb                registered APB master outputs
//   prdata, pready, pslverr    APB completer response
module apb_master_arb #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int STRB_W  = DATA_W / 8,
   parameter int TIMEOUT = 255
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [1:0]            rq_valid,
   input  logic [1:0]            rq_write,
   input  logic [2*ADDR_W-1:0]   rq_addr,
   input  logic [2*DATA_W-1:0]   rq_wdata,
   input  logic [2*STRB_W-1:0]   rq_strb,
   output logic [1:0]            rq_done,
   output logic [DATA_W-1:0]     rq_rdata,
   output logic                  rq_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_W-1:0]     paddr,
   output logic [DATA_W-1:0]     pwdata,
   output logic [STRB_W-1:0]     pstrb,
   input  logic [DATA_W-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t              state, state_nxt;
   logic                last_grant, last_grant_nxt;
   logic [15:0]         tmo_cnt, tmo_cnt_nxt, tmo_inc;
   logic [1:0]          elig;
   logic                pick;
   logic                finish;
   logic                psel_nxt, penable_nxt, pwrite_nxt, rq_err_nxt;
   logic [ADDR_W-1:0]   paddr_nxt;
   logic [DATA_W-1:0]   pwdata_nxt, rq_rdata_nxt;
   logic [STRB_W-1:0]   pstrb_nxt;
   logic [1:0]          rq_done_nxt;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      tmo_cnt_nxt    = tmo_cnt;
      psel_nxt       = psel;
      penable_nxt    = penable;
      pwrite_nxt     = pwrite;
      paddr_nxt      = paddr;
      pwdata_nxt     = pwdata;
      pstrb_nxt      = pstrb;
      rq_done_nxt    = 2'b00;
      rq_rdata_nxt   = rq_rdata;
      rq_err_nxt     = rq_err;
      finish         = 1'b0;
      tmo_inc        = tmo_cnt + 16'd1;
      // A requester being told "done" this cycle has not yet had a chance to drop
      // its valid, so it must not be re-granted on the same edge.
      elig = rq_valid & ~rq_done;
      pick = (elig == 2'b11) ? ~last_grant : elig[1];

      case (state)
         IDLE: begin
            if (|elig) begin
               last_grant_nxt = pick;
               psel_nxt       = 1'b1;
               pwrite_nxt     = rq_write[pick];
               paddr_nxt      = pick ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
               if (rq_write[pick]) begin
                  pwdata_nxt = pick ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
                  pstrb_nxt  = pick ? rq_strb[2*STRB_W-1:STRB_W] : rq_strb[STRB_W-1:0];
               end else begin
                  pwdata_nxt = '0;
                  pstrb_nxt  = '0;
               end
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            penable_nxt = 1'b1;
            tmo_cnt_nxt = '0;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            // pready is checked first so a response arriving on the last allowed
            // cycle completes normally rather than timing out.
            if (pready) begin
               finish       = 1'b1;
               rq_rdata_nxt = pwrite ? rq_rdata : prdata;
               rq_err_nxt   = pslverr;
            end else if (tmo_inc == TMO) begin
               finish       = 1'b1;
               rq_rdata_nxt = '0;
               rq_err_nxt   = 1'b1;
            end else begin
               tmo_cnt_nxt  = tmo_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (finish) begin
         rq_done_nxt = last_grant ? 2'b10 : 2'b01;
         psel_nxt    = 1'b0;
         penable_nxt = 1'b0;
         pwrite_nxt  = 1'b0;
         pwdata_nxt  = '0;
         pstrb_nxt   = '0;
         state_nxt   = IDLE;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         last_grant <= 1'b1;
         tmo_cnt    <= '0;
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         pstrb      <= '0;
         rq_done    <= 2'b00;
         rq_rdata   <= '0;
         rq_err     <= 1'b0;
      end else begin
         last_grant <= last_grant_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         psel       <= psel_nxt;
         penable    <= penable_nxt;
         pwrite     <= pwrite_nxt;
         paddr      <= paddr_nxt;
         pwdata     <= pwdata_nxt;
         pstrb      <= pstrb_nxt;
         rq_done    <= rq_done_nxt;
         rq_rdata   <= rq_rdata_nxt;
         rq_err     <= rq_err_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with TIMEOUT=4: reset, write, wait-state read,
// rdata hold on write, timeout, round-robin alternation and mid-transfer reset.
module tb_apb_master_arb;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   logic                pclk = 1'b0;
   logic                presetn;
   logic [1:0]          rq_valid;
   logic [1:0]          rq_write;
   logic [2*ADDR_W-1:0] rq_addr;
   logic [2*DATA_W-1:0] rq_wdata;
   logic [2*STRB_W-1:0] rq_strb;
   logic [1:0]          rq_done;
   logic [DATA_W-1:0]   rq_rdata;
   logic                rq_err;
   logic                psel, penable, pwrite;
   logic [ADDR_W-1:0]   paddr;
   logic [DATA_W-1:0]   pwdata;
   logic [STRB_W-1:0]   pstrb;
   logic [DATA_W-1:0]   prdata;
   logic                pready, pslverr;

   int checks = 0;
   int errors = 0;

   apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .TIMEOUT(4)) dut (
      .pclk(pclk), .presetn(presetn),
      .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr),
      .rq_wdata(rq_wdata), .rq_strb(rq_strb),
      .rq_done(rq_done), .rq_rdata(rq_rdata), .rq_err(rq_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   // Advance one cycle; drive and sample 1ns after the rising edge.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      presetn  = 1'b0;
      rq_valid = 2'b00; rq_write = 2'b00; rq_addr = '0; rq_wdata = '0; rq_strb = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      tick(); tick();
      checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL rst_ctl: got %b exp 000", {psel, penable, pwrite}); end
      checks++; if ({paddr, pwdata, pstrb} !== '0) begin errors++; $display("FAIL rst_bus: got %h %h %h exp 0", paddr, pwdata, pstrb); end
      checks++; if ({rq_done, rq_rdata, rq_err} !== '0) begin errors++; $display("FAIL rst_rq: got %b %h %b exp 0", rq_done, rq_rdata, rq_err); end
      presetn = 1'b1;
   endtask

   // Requester 0 write, zero wait states; issued right after reset release.
   task automatic test_write();
      rq_valid = 2'b01; rq_write = 2'b01;
      rq_addr = {12'h0, 12'h010}; rq_wdata = {32'h0, 32'hDEADBEEF}; rq_strb = {4'h0, 4'hF};
      pready = 1'b1;
      tick();  // cycle 1
      checks++; if ({psel, penable, pwrite} !== 3'b101) begin errors++; $display("FAIL wr_setup_ctl: got %b exp 101", {psel, penable, pwrite}); end
      checks++; if (paddr !== 12'h010 || pwdata !== 32'hDEADBEEF || pstrb !== 4'hF) begin errors++; $display("FAIL wr_setup_bus: got %h %h %h exp 010 deadbeef f", paddr, pwdata, pstrb); end
      tick();  // cycle 2
      checks++; if ({psel, penable, rq_done} !== 4'b1100) begin errors++; $display("FAIL wr_access: got %b exp 1100", {psel, penable, rq_done}); end
      tick();  // cycle 3
      checks++; if (rq_done !== 2'b01 || rq_err !== 1'b0) begin errors++; $display("FAIL wr_done: got %b err %b exp 01 err 0", rq_done, rq_err); end
      checks++; if ({psel, penable, pwrite, pwdata, pstrb} !== '0 || paddr !== 12'h010) begin errors++; $display("FAIL wr_idle_bus: got %b%b%b %h %h addr %h", psel, penable, pwrite, pwdata, pstrb, paddr); end
      rq_valid = 2'b00;
      tick();
      checks++; if (rq_done !== 2'b00 || psel !== 1'b0) begin errors++; $display("FAIL wr_after: got done %b psel %b exp 00 0", rq_done, psel); end
   endtask

   // Requester 1 read, three wait states, response lands on the 4th ACCESS cycle.
   task automatic test_read_wait();
      rq_valid = 2'b10; rq_write = 2'b00;
      rq_addr = {12'h024, 12'h0}; rq_wdata = {32'h55555555, 32'h0}; rq_strb = {4'hF, 4'h0};
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      tick();  // SETUP
      checks++; if (paddr !== 12'h024 || pwrite !== 1'b0 || pwdata !== '0 || pstrb !== '0) begin errors++; $display("FAIL rd_setup: got %h %b %h %h exp 024 0 0 0", paddr, pwrite, pwdata, pstrb); end
      tick(); tick(); tick();  // ACCESS 1..3
      checks++; if ({psel, penable, rq_done} !== 4'b1100) begin errors++; $display("FAIL rd_wait: got %b exp 1100", {psel, penable, rq_done}); end
      tick();  // ACCESS 4
      checks++; if ({psel, penable, rq_done} !== 4'b1100) begin errors++; $display("FAIL rd_wait4: got %b exp 1100", {psel, penable, rq_done}); end
      pready = 1'b1; prdata = 32'h12345678; pslverr = 1'b1;
      tick();
      checks++; if (rq_done !== 2'b10) begin errors++; $display("FAIL rd_done: got %b exp 10", rq_done); end
      checks++; if (rq_rdata !== 32'h12345678 || rq_err !== 1'b1) begin errors++; $display("FAIL rd_data: got %h err %b exp 12345678 err 1", rq_rdata, rq_err); end
      rq_valid = 2'b00; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      tick();
   endtask

   // A write completion must leave rq_rdata untouched while updating rq_err.
   task automatic test_write_keeps_rdata();
      rq_valid = 2'b01; rq_write = 2'b01;
      rq_addr = {12'h0, 12'h040}; rq_wdata = {32'h0, 32'h0BADF00D}; rq_strb = {4'h0, 4'h3};
      pready = 1'b1; prdata = 32'hFFFFFFFF;
      tick(); tick(); tick();
      checks++; if (rq_done !== 2'b01 || rq_rdata !== 32'h12345678 || rq_err !== 1'b0) begin errors++; $display("FAIL wr_hold: got %b %h %b exp 01 12345678 0", rq_done, rq_rdata, rq_err); end
      rq_valid = 2'b00; pready = 1'b0; prdata = 32'h0;
      tick();
   endtask

   // pready stuck low: forced completion after 4 ACCESS cycles, then a normal read.
   task automatic test_timeout();
      rq_valid = 2'b01; rq_write = 2'b00; rq_addr = {12'h0, 12'h0FC};
      pready = 1'b0; prdata = 32'hAAAA5555;
      tick();                          // SETUP
      tick(); tick(); tick(); tick();  // ACCESS 1..4
      checks++; if ({penable, rq_done} !== 3'b100) begin errors++; $display("FAIL to_wait: got %b exp 100", {penable, rq_done}); end
      tick();
      checks++; if (rq_done !== 2'b01 || rq_err !== 1'b1 || rq_rdata !== 32'h0) begin errors++; $display("FAIL to_done: got %b %b %h exp 01 1 0", rq_done, rq_err, rq_rdata); end
      checks++; if ({psel, penable} !== 2'b00) begin errors++; $display("FAIL to_idle: got %b exp 00", {psel, penable}); end
      rq_valid = 2'b00;
      tick();
      rq_valid = 2'b01; pready = 1'b1; prdata = 32'hCAFEF00D;
      tick(); tick(); tick();
      checks++; if (rq_done !== 2'b01 || rq_err !== 1'b0 || rq_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL to_next: got %b %b %h exp 01 0 cafef00d", rq_done, rq_err, rq_rdata); end
      rq_valid = 2'b00; pready = 1'b0;
      tick();
   endtask

   // Both requesting continuously; last grant was requester 0, so 1 goes first.
   task automatic test_round_robin();
      logic [1:0] exp_done;
      int n = 0;
      int last_cyc = 0;
      rq_valid = 2'b11; rq_write = 2'b00; rq_addr = {12'h200, 12'h100};
      pready = 1'b1; prdata = 32'h00C0FFEE;
      exp_done = 2'b10;
      for (int cyc = 1; cyc <= 60 && n < 8; cyc++) begin
         tick();
         if (rq_done !== 2'b00) begin
            checks++; if (rq_done !== exp_done) begin errors++; $display("FAIL rr_order%0d: got %b exp %b", n, rq_done, exp_done); end
            if (n > 0) begin
               checks++; if (cyc - last_cyc !== 3) begin errors++; $display("FAIL rr_gap%0d: got %0d exp 3", n, cyc - last_cyc); end
            end
            last_cyc = cyc;
            exp_done = ~exp_done;
            n++;
         end
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL rr_count: got %0d exp 8", n); end
      rq_valid = 2'b00;
      for (int i = 0; i < 5; i++) tick();
      checks++; if ({psel, rq_done} !== 3'b000) begin errors++; $display("FAIL rr_drain: got %b exp 000", {psel, rq_done}); end
   endtask

   // Reset asserted mid-ACCESS: outputs clear without a clock edge and no rq_done.
   task automatic test_reset_mid();
      rq_valid = 2'b01; rq_write = 2'b01; rq_addr = {12'h200, 12'h100};
      rq_wdata = {32'h0, 32'h11112222}; rq_strb = {4'h0, 4'hF};
      pready = 1'b0;
      tick(); tick(); tick();  // SETUP, ACCESS, ACCESS
      checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rm_pre: got %b exp 11", {psel, penable}); end
      #1 presetn = 1'b0;
      #1;
      checks++; if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin errors++; $display("FAIL rm_async_bus: got %b%b%b %h %h %h exp 0", psel, penable, pwrite, paddr, pwdata, pstrb); end
      checks++; if ({rq_done, rq_rdata, rq_err} !== '0) begin errors++; $display("FAIL rm_async_rq: got %b %h %b exp 0", rq_done, rq_rdata, rq_err); end
      rq_valid = 2'b11; pready = 1'b1;
      tick(); tick();
      checks++; if ({psel, rq_done} !== 3'b000) begin errors++; $display("FAIL rm_held: got %b exp 000", {psel, rq_done}); end
      presetn = 1'b1;
      tick();
      checks++; if (psel !== 1'b1 || paddr !== 12'h100 || rq_done !== 2'b00) begin errors++; $display("FAIL rm_first_grant: got %b %h %b exp 1 100 00", psel, paddr, rq_done); end
      tick(); tick();
      checks++; if (rq_done !== 2'b01) begin errors++; $display("FAIL rm_done: got %b exp 01", rq_done); end
      rq_valid = 2'b00; pready = 1'b0;
      tick(); tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_write_keeps_rdata();
      test_timeout();
      test_round_robin();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter ADDR_W, default 12: APB and requester address width.
REQ-002 Parameter DATA_W, default 32: APB and requester data width.
REQ-003 Parameter STRB_W, default DATA_W/8: write-strobe width.
REQ-004 Parameter TIMEOUT, default 255: maximum ACCESS cycles without pready before forced termination; legal range 1..65535.
REQ-005 Port pclk, input, 1: the single clock; all logic rising-edge.
REQ-006 Port presetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port rq_valid, input, 2: per-requester transfer request; held until that requester's rq_done.
REQ-008 Port rq_write, input, 2: per-requester direction, 1 = write.
REQ-009 Port rq_addr, input, 2*ADDR_W: requester i owns bits [i*ADDR_W +: ADDR_W].
REQ-010 Port rq_wdata, input, 2*DATA_W: requester i owns bits [i*DATA_W +: DATA_W].
REQ-011 Port rq_strb, input, 2*STRB_W: requester i owns bits [i*STRB_W +: STRB_W].
REQ-012 Port rq_done, output, 2: one-cycle completion pulse to the granted requester.
REQ-013 Port rq_rdata, output, DATA_W: read data of the last completed transfer.
REQ-014 Port rq_err, output, 1: error flag of the last completed transfer.
REQ-015 Ports psel, penable, pwrite (output, 1), paddr (output, ADDR_W), pwdata (output, DATA_W), pstrb (output, STRB_W): APB master outputs, all registered.
REQ-016 Ports prdata (input, DATA_W), pready (input, 1), pslverr (input, 1): APB completer responses.

Function
REQ-017 FSM has states IDLE, SETUP, ACCESS.
REQ-018 IDLE: psel=0, penable=0, pwrite=0, pwdata=0, pstrb=0; paddr holds its last value.
REQ-019 IDLE with at least one eligible rq_valid: grant one requester, register its addr/write/wdata/strb onto the APB outputs, set psel=1, and go to SETUP.
REQ-020 A read registers pwdata=0 and pstrb=0.
REQ-021 Arbitration is round-robin: with both requesters eligible, grant the one not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-022 A requester whose rq_done is high in the current cycle is ineligible in that cycle.
REQ-023 SETUP lasts exactly one cycle (psel=1, penable=0), then ACCESS with penable=1.
REQ-024 ACCESS: sample pready each cycle; APB outputs stay stable until completion.
REQ-025 ACCESS with pready=1 at an edge:
  - next cycle: rq_done[grant]=1, rq_rdata=prdata (reads), rq_rdata unchanged (writes), rq_err=pslverr;
  - psel=0, penable=0, pwrite=0, pwdata=0, pstrb=0; state IDLE.
REQ-026 Minimum transfer: valid seen in cycle 0, SETUP cycle 1, ACCESS cycle 2, rq_done cycle 3.
REQ-027 Timeout counter: 16 bits; cleared on entering ACCESS; increments each ACCESS cycle with pready=0.
REQ-028 When the counter equals TIMEOUT with pready=0: terminate as in REQ-025 with rq_err=1 and rq_rdata=0.
REQ-029 pready=1 in the same cycle the counter reaches TIMEOUT: normal completion (REQ-025) takes precedence.
REQ-030 rq_rdata and rq_err hold until the next completion; rq_done is never high for both bits together.
REQ-031 Requester behaviour is unspecified if rq_valid drops or request fields change before rq_done; the block uses the registered copy.

Reset
REQ-032 presetn low forces state IDLE, all outputs 0 (including paddr, rq_rdata, rq_err, rq_done), timeout counter 0, last_grant 1, asynchronously.
REQ-033 Reset mid-transfer aborts it: no rq_done is issued, and psel/penable drop immediately.
REQ-034 The first eligible request after presetn rises is granted on the first rising edge.

Verification
REQ-035 Single write, rq 0, addr 0x010, data 0xDEADBEEF, strb 0xF, pready=1: psel in cycle 1, penable in cycle 2, rq_done=2'b01 in cycle 3, rq_err=0.
REQ-036 Read, rq 1, addr 0x024, pready low for 3 ACCESS cycles then high with prdata 0x12345678, pslverr=1: rq_done=2'b10, rq_rdata=0x12345678, rq_err=1.
REQ-037 Both valid continuously, 4 transfers each: grants alternate 0,1,0,1,...; no back-to-back re-grant of the finishing requester.
REQ-038 TIMEOUT=4, pready stuck at 0: rq_done after 4 ACCESS cycles with rq_err=1 and rq_rdata=0; next transfer completes normally.
REQ-039 presetn pulsed low during ACCESS: psel=0 and all outputs 0 asynchronously, no rq_done; after release, requester 0 wins the first tie.
